// File: rtl/redux_acc_if.sv
// Stream interface for redux_acc: operand beats in, per-packet totals out.
interface redux_acc_if #(
  parameter int W  = 17,
  parameter int M  = 13,
  parameter int CW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [M*W-1:0] in_data;
  logic [M-1:0]  in_mask;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_count;

  // Producer / result consumer side
  modport master (
    output in_valid, in_data, in_mask, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_data, in_mask, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/redux_acc.sv
// Sequential multi-operand accumulator. Each accepted beat folds up to M
// masked operands plus the carry-save running total through an N:2
// reductor; the final beat of a packet resolves the carry-save pair into
// a single W-bit sum that is held until the consumer takes it.

// N:2 carry-save reductor: q[0] + q[1] == sum of all d[i] modulo 2^W.
module redux #(
  parameter int W = 17,
  parameter int N = 15
) (
  input  logic [N-1:0][W-1:0] d,
  output logic [1:0][W-1:0]   q
);
  // Chain of 3:2 compressors; no carry propagation until the caller adds q[0]+q[1]
  always_comb begin : reduce
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic [W-1:0] t;
    s = d[0];
    c = d[1];
    t = '0;
    for (int i = 2; i < N; i++) begin
      t = s ^ c ^ d[i];
      c = ((s & c) | (s & d[i]) | (c & d[i])) << 1;
      s = t;
    end
    q[0] = s;
    q[1] = c;
  end
endmodule

module redux_acc #(
  parameter int W  = 17,
  parameter int M  = 13,
  parameter int CW = 16
) (
  input logic        clock,
  input logic        reset,
  redux_acc_if.slave bus
);
  localparam int PW = $clog2(M + 1);
  localparam int SW = ((CW > PW) ? CW : PW) + 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 accept;
  logic [W-1:0]         acc0;
  logic [W-1:0]         acc1;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_next;
  logic [PW-1:0]        pop;
  logic [SW-1:0]        cnt_sum;
  logic [W-1:0]         sum_q;
  logic [CW-1:0]        count_q;
  logic [M+1:0][W-1:0]  red_in;
  logic [1:0][W-1:0]    red_q;

  // Handshake flags come straight from the state so no input feeds them
  assign bus.in_ready  = (state_q != DONE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_count = count_q;
  assign accept        = bus.in_valid & bus.in_ready;

  // Zero masked lanes and append the carry-save running total
  always_comb begin
    red_in = '0;
    for (int i = 0; i < M; i++) begin
      red_in[i] = bus.in_mask[i] ? bus.in_data[i*W +: W] : '0;
    end
    red_in[M]   = acc0;
    red_in[M+1] = acc1;
  end

  redux #(.W(W), .N(M + 2)) u_redux (
    .d(red_in),
    .q(red_q)
  );

  // Operand count for this beat and saturating running count
  always_comb begin
    pop = '0;
    for (int i = 0; i < M; i++) begin
      pop = pop + PW'(bus.in_mask[i]);
    end
    cnt_sum  = SW'(cnt) + SW'(pop);
    cnt_next = (cnt_sum > SW'({CW{1'b1}})) ? {CW{1'b1}} : cnt_sum[CW-1:0];
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: last beat parks in DONE until the result is taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) state_d = bus.in_last ? DONE : ACC;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: fold beats into the carry-save pair, resolve on the last beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc0    <= '0;
      acc1    <= '0;
      cnt     <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      if (bus.in_last) begin
        sum_q   <= red_q[0] + red_q[1];
        count_q <= cnt_next;
        acc0    <= '0;
        acc1    <= '0;
        cnt     <= '0;
      end else begin
        acc0 <= red_q[0];
        acc1 <= red_q[1];
        cnt  <= cnt_next;
      end
    end
  end
endmodule

// File: tb/tb_redux_acc.sv
// Scoreboard bench for redux_acc: stimulus pushes expected packet results,
// a negedge monitor compares them whenever a result is presented.
module tb_redux_acc;
  localparam int W   = 17;
  localparam int M   = 13;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  typedef struct packed {
    logic [W-1:0]  sum;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [W-1:0]   sum;
    logic [CW4-1:0] cnt;
  } exp4_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  exp_t  exp_q[$];
  exp4_t exp4_q[$];
  logic rand_ready = 1'b0;
  logic rand_val   = 1'b0;
  logic man_ready  = 1'b0;

  redux_acc_if #(.W(W), .M(M), .CW(CW))  bus ();
  redux_acc_if #(.W(W), .M(M), .CW(CW4)) bus4 ();

  redux_acc #(.W(W), .M(M), .CW(CW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  redux_acc #(.W(W), .M(M), .CW(CW4)) dut4 (
    .clock(clock),
    .reset(reset),
    .bus(bus4)
  );

  always #5 clock = ~clock;

  assign bus.out_ready  = rand_ready ? rand_val : man_ready;
  assign bus4.out_ready = 1'b1;

  // Random consumer back-pressure
  always @(posedge clock) rand_val <= 1'($urandom_range(0, 1));

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] s, input logic [CW-1:0] c);
    exp_t e;
    e.sum = s;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  function automatic logic [M*W-1:0] all_lanes(input logic [W-1:0] v);
    logic [M*W-1:0] r;
    for (int i = 0; i < M; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [M*W-1:0] rand_lanes();
    logic [M*W-1:0] r;
    for (int i = 0; i < M; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Issue one beat on the main DUT after 'gap' idle cycles of garbage
  task automatic apply_stimulus(input logic [M*W-1:0] data, input logic [M-1:0] mask,
                                input logic last, input int gap);
    bit done;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = rand_lanes();
      bus.in_mask  = M'($urandom);
      bus.in_last  = 1'($urandom);
      wait_cycles(1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_mask  = mask;
    bus.in_last  = last;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clock);
      done = bus.in_ready;
      @(posedge clock);
      #1;
    end
    if (!done) check_output("accept_timeout", 32'(done), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // Issue one beat on the CW=4 DUT
  task automatic apply_stimulus4(input logic [M*W-1:0] data, input logic [M-1:0] mask,
                                 input logic last);
    bit done;
    bus4.in_valid = 1'b1;
    bus4.in_data  = data;
    bus4.in_mask  = mask;
    bus4.in_last  = last;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clock);
      done = bus4.in_ready;
      @(posedge clock);
      #1;
    end
    if (!done) check_output("accept4_timeout", 32'(done), 32'd1);
    bus4.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && (exp_q.size() != 0 || exp4_q.size() != 0); k++) wait_cycles(1);
    if (exp_q.size() != 0)  check_output("drain_main", exp_q.size(), 0);
    if (exp4_q.size() != 0) check_output("drain_cw4", exp4_q.size(), 0);
  endtask

  // Monitor for the main DUT: compare head every DONE cycle, pop on handshake
  always @(negedge clock) begin
    if (!reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_result", exp_q.size(), 1);
      end else begin
        check_output("out_sum", 32'(bus.out_sum), 32'(exp_q[0].sum));
        check_output("out_count", 32'(bus.out_count), 32'(exp_q[0].cnt));
        check_output("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Monitor for the CW=4 DUT
  always @(negedge clock) begin
    if (!reset && bus4.out_valid) begin
      if (exp4_q.size() == 0) begin
        check_output("unexpected_result4", exp4_q.size(), 1);
      end else begin
        check_output("out_sum_cw4", 32'(bus4.out_sum), 32'(exp4_q[0].sum));
        check_output("out_count_cw4", 32'(bus4.out_count), 32'(exp4_q[0].cnt));
        void'(exp4_q.pop_front());
      end
    end
  end

  initial begin
    logic [M*W-1:0] data;
    logic [M-1:0]   mask;
    logic [W-1:0]   msum;
    int             mcnt;
    int             nb;
    exp4_t          e4;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mask   = '0;
    bus.in_last   = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.in_data  = '0;
    bus4.in_mask  = '0;
    bus4.in_last  = 1'b0;

    #12;
    check_output("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("reset_out_sum", 32'(bus.out_sum), 32'd0);
    check_output("reset_out_count", 32'(bus.out_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    wait_cycles(1);

    // Single beat, all lanes 1: held while out_ready low, drops after handshake
    man_ready = 1'b0;
    push_exp(17'd13, 16'd13);
    apply_stimulus(all_lanes(17'd1), '1, 1'b1, 0);
    check_output("latency_valid", 32'(bus.out_valid), 32'd1);
    wait_cycles(5);
    check_output("held_valid", 32'(bus.out_valid), 32'd1);
    man_ready = 1'b1;
    wait_cycles(1);
    check_output("drop_valid", 32'(bus.out_valid), 32'd0);

    // Wrap-around: 26 * 0x1FFFF mod 2^17
    push_exp(17'h1FFE6, 16'd26);
    apply_stimulus(all_lanes(17'h1FFFF), '1, 1'b0, 1);
    apply_stimulus(all_lanes(17'h1FFFF), '1, 1'b1, 0);

    // Masked lanes carry garbage; only lane 0 counts
    push_exp(17'h1FFFF, 16'd3);
    apply_stimulus(all_lanes(17'h15555), 13'h0001, 1'b0, 0);
    apply_stimulus(all_lanes(17'h15555), 13'h0001, 1'b0, 2);
    apply_stimulus(all_lanes(17'h15555), 13'h0001, 1'b1, 0);

    // Single empty-mask last beat
    push_exp(17'd0, 16'd0);
    apply_stimulus(all_lanes(17'h0ABCD), '0, 1'b1, 0);

    // Empty-mask beat inside a packet adds nothing: 5 lanes of 0x10
    push_exp(17'h00050, 16'd5);
    apply_stimulus(all_lanes(17'h1FFFF), '0, 1'b0, 0);
    apply_stimulus(all_lanes(17'h00010), 13'h1F00, 1'b1, 1);
    drain();

    // Reset mid-packet discards the partial total
    apply_stimulus(all_lanes(17'd3), '1, 1'b0, 0);
    apply_stimulus(all_lanes(17'd3), '1, 1'b0, 0);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_output("midreset_out_sum", 32'(bus.out_sum), 32'd0);
    check_output("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    wait_cycles(1);
    @(negedge clock);
    reset = 1'b0;
    wait_cycles(1);
    data = all_lanes(17'h1ABCD);
    data[W-1:0] = 17'd5;
    push_exp(17'd5, 16'd1);
    apply_stimulus(data, 13'h0001, 1'b1, 0);
    drain();

    // Reset in DONE drops out_valid before the next clock edge
    man_ready = 1'b0;
    data = all_lanes(17'h0F0F0);
    data[W-1:0] = 17'd7;
    push_exp(17'd7, 16'd1);
    apply_stimulus(data, 13'h0001, 1'b1, 0);
    wait_cycles(1);
    check_output("done_before_reset", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_output("async_drop_valid", 32'(bus.out_valid), 32'd0);
    check_output("async_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("async_out_sum", 32'(bus.out_sum), 32'd0);
    check_output("async_out_count", 32'(bus.out_count), 32'd0);
    wait_cycles(1);
    @(negedge clock);
    reset = 1'b0;
    man_ready = 1'b1;
    wait_cycles(1);

    // Random packets against a plain arithmetic model
    rand_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      nb   = $urandom_range(1, 8);
      msum = '0;
      mcnt = 0;
      for (int b = 0; b < nb; b++) begin
        data = rand_lanes();
        mask = M'($urandom);
        for (int i = 0; i < M; i++) begin
          if (mask[i]) begin
            msum = msum + data[i*W +: W];
            mcnt = mcnt + 1;
          end
        end
        if (b == nb - 1) push_exp(msum, CW'(mcnt));
        apply_stimulus(data, mask, (b == nb - 1), $urandom_range(0, 2));
      end
    end
    drain();
    rand_ready = 1'b0;

    // CW=4 instance: 26 operands saturate the count at 15; lanes 1..13 sum 91 per beat
    for (int i = 0; i < M; i++) data[i*W +: W] = W'(i + 1);
    e4.sum = 17'd182;
    e4.cnt = 4'd15;
    exp4_q.push_back(e4);
    apply_stimulus4(data, '1, 1'b0);
    apply_stimulus4(data, '1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
